// File: rtl/fir_sample_tx.sv
// Serial transmitter for filtered samples: requantizes each sample (round-half-up,
// saturate) and shifts it out MSB first with a frame marker on the first bit.
module fir_sample_tx #(
   parameter int IN_W    = 18,
   parameter int OUT_W   = 12,
   parameter int SHIFT   = 6,
   parameter int CLK_DIV = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] sample_in,
   input  logic            sample_valid,
   output logic            sample_ready,
   output logic            ser_data,
   output logic            ser_frame,
   output logic            busy,
   output logic            sat,
   output logic            overflow,
   input  logic            ovf_clr
);

   localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
   localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [IN_W:0] MAX_Q = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IN_W:0] MIN_Q = ~MAX_Q;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   logic [OUT_W-1:0] shreg_r;
   logic [BIT_W-1:0] bit_cnt_r;
   logic [DIV_W-1:0] div_cnt_r;
   logic             frame_r;
   logic             busy_r;
   logic             sat_r;
   logic             ovf_r;

   logic             accept_s;
   logic             drop_s;
   logic             bit_end_s;
   logic             frame_end_s;
   logic             ready_s;
   logic [OUT_W:0]   quant_s;

   // Returns {sat, word}; one guard bit keeps the rounding add from wrapping.
   function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] sum;
      logic signed [IN_W:0] q;
      logic [OUT_W:0]       res;
      sum = $signed({x[IN_W-1], x}) + HALF;
      q   = sum >>> SHIFT;
      if (q > MAX_Q) begin
         res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end else if (q < MIN_Q) begin
         res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         res = {1'b0, q[OUT_W-1:0]};
      end
      return res;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (frame_end_s && !accept_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake and bit-timing decode.
   always_comb begin
      bit_end_s   = 1'b0;
      frame_end_s = 1'b0;
      ready_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
         end
         ST_SHIFT: begin
            bit_end_s   = (div_cnt_r == LAST_DIV);
            frame_end_s = bit_end_s && (bit_cnt_r == LAST_BIT);
            ready_s     = frame_end_s;
         end
         default: begin
            ready_s = 1'b0;
         end
      endcase
      accept_s = sample_valid && ready_s;
      drop_s   = sample_valid && !ready_s;
      quant_s  = requant(sample_in);
   end

   assign sample_ready = ready_s;

   // Shift datapath, framing flags and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg_r   <= {OUT_W{1'b0}};
         bit_cnt_r <= {BIT_W{1'b0}};
         div_cnt_r <= {DIV_W{1'b0}};
         frame_r   <= 1'b0;
         busy_r    <= 1'b0;
         sat_r     <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         if (accept_s) begin
            shreg_r   <= quant_s[OUT_W-1:0];
            sat_r     <= quant_s[OUT_W];
            bit_cnt_r <= {BIT_W{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
            frame_r   <= 1'b1;
            busy_r    <= 1'b1;
         end else if (frame_end_s) begin
            // Clearing the shifter makes ser_data idle low.
            shreg_r   <= {OUT_W{1'b0}};
            sat_r     <= 1'b0;
            bit_cnt_r <= {BIT_W{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
            frame_r   <= 1'b0;
            busy_r    <= 1'b0;
         end else if (bit_end_s) begin
            shreg_r   <= {shreg_r[OUT_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            div_cnt_r <= {DIV_W{1'b0}};
            frame_r   <= 1'b0;
         end else if (state_r == ST_SHIFT) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end else begin
            div_cnt_r <= {DIV_W{1'b0}};
         end

         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   assign ser_data  = shreg_r[OUT_W-1];
   assign ser_frame = frame_r;
   assign busy      = busy_r;
   assign sat       = sat_r;
   assign overflow  = ovf_r;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Self-checking bench for fir_sample_tx: table vectors, hand-written corner
// sequences and random traffic against a time-based frame model.
module tb_fir_sample_tx;

   localparam int IN_W    = 18;
   localparam int OUT_W   = 12;
   localparam int SHIFT   = 6;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = OUT_W * CLK_DIV;

   logic            clk = 1'b0;
   logic            rst;
   logic [IN_W-1:0] sample_in;
   logic            sample_valid;
   logic            sample_ready;
   logic            ser_data;
   logic            ser_frame;
   logic            busy;
   logic            sat;
   logic            overflow;
   logic            ovf_clr;

   fir_sample_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .ser_data(ser_data), .ser_frame(ser_frame),
      .busy(busy), .sat(sat), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: a frame is the edge it was accepted on plus its word; everything
   // else follows from elapsed time since that edge.
   int               edge_n    = 0;
   int               cur_start = -1;
   logic [OUT_W-1:0] m_word    = '0;
   logic             m_sat     = 1'b0;
   logic             m_ovf     = 1'b0;

   typedef struct {
      logic [IN_W-1:0]  x;
      logic [OUT_W-1:0] word;
      logic             s;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic void quant(input logic [IN_W-1:0] x, output logic [OUT_W-1:0] w,
                                 output logic s);
      int xi;
      int q;
      int lim;
      xi  = int'($signed(x));
      q   = (xi + (1 << (SHIFT - 1))) >>> SHIFT;
      lim = 1 << (OUT_W - 1);
      s   = 1'b0;
      if (q > lim - 1) begin
         q = lim - 1;
         s = 1'b1;
      end else if (q < -lim) begin
         q = -lim;
         s = 1'b1;
      end
      w = OUT_W'(q);
   endfunction

   function automatic logic model_ready(input int e);
      return (cur_start < 0) || (e >= cur_start + FRAME);
   endfunction

   task automatic step(input logic r, input logic v, input logic [IN_W-1:0] d, input logic c);
      logic drop;
      int   k;
      logic e_data, e_frame, e_busy, e_sat;
      rst = r; sample_valid = v; sample_in = d; ovf_clr = c;
      @(posedge clk);
      edge_n++;
      if (!r) begin
         cur_start = -1;
         m_ovf     = 1'b0;
      end else begin
         drop = 1'b0;
         if (v) begin
            if (model_ready(edge_n)) begin
               cur_start = edge_n;
               quant(d, m_word, m_sat);
            end else begin
               drop = 1'b1;
            end
         end
         if (drop) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
      end
      e_data = 1'b0; e_frame = 1'b0; e_busy = 1'b0; e_sat = 1'b0;
      if (cur_start >= 0 && edge_n - cur_start < FRAME) begin
         k       = edge_n - cur_start;
         e_data  = m_word[OUT_W - 1 - k / CLK_DIV];
         e_frame = (k < CLK_DIV);
         e_busy  = 1'b1;
         e_sat   = m_sat;
      end
      #1;
      chk("ser_data", 32'(ser_data), 32'(e_data));
      chk("ser_frame", 32'(ser_frame), 32'(e_frame));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("sat", 32'(sat), 32'(e_sat));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("sample_ready", 32'(sample_ready), 32'(model_ready(edge_n + 1)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
   endtask

   // Strobe one sample from idle and deserialize its frame at bit centres.
   task automatic run_frame(input logic [IN_W-1:0] x, output logic [OUT_W-1:0] w,
                            output logic s);
      w = '0;
      step(1'b1, 1'b1, x, 1'b0);
      s = sat;
      for (int k = 1; k < FRAME; k++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         if (k % CLK_DIV == CLK_DIV / 2) w = {w[OUT_W-2:0], ser_data};
      end
   endtask

   vec_t vecs[8];

   initial begin
      logic [OUT_W-1:0] w;
      logic             s;
      int               fr_cnt;
      int               busy_cnt;

      vecs[0] = '{18'h00040, 12'h001, 1'b0};
      vecs[1] = '{18'd95,    12'h001, 1'b0};
      vecs[2] = '{18'd96,    12'h002, 1'b0};
      vecs[3] = '{18'h3FFDF, 12'hFFF, 1'b0};
      vecs[4] = '{18'h3FFE0, 12'h000, 1'b0};
      vecs[5] = '{18'h1FFFF, 12'h7FF, 1'b1};
      vecs[6] = '{18'h20000, 12'h800, 1'b0};
      vecs[7] = '{18'h1FFDF, 12'h7FF, 1'b0};

      // Reset held while strobing: nothing may start.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 18'h00040, 1'b0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_data", 32'(ser_data), 32'd0);

      // First frame after release: count frame and busy cycles.
      fr_cnt = 0; busy_cnt = 0;
      step(1'b1, 1'b1, 18'h00040, 1'b0);
      for (int i = 0; i < FRAME + 4; i++) begin
         fr_cnt   += int'(ser_frame);
         busy_cnt += int'(busy);
         if (i < FRAME + 3) step(1'b1, 1'b0, '0, 1'b0);
      end
      chk("frame_len", 32'(fr_cnt), 32'(CLK_DIV));
      chk("busy_len", 32'(busy_cnt), 32'(FRAME));

      // Table-driven requantization vectors.
      foreach (vecs[i]) begin
         run_frame(vecs[i].x, w, s);
         chk("vec_word", 32'(w), 32'(vecs[i].word));
         chk("vec_sat", 32'(s), 32'(vecs[i].s));
         idle(2);
      end

      // Back-to-back: B strobed on A's final frame cycle.
      step(1'b1, 1'b1, 18'h01000, 1'b0);
      idle(FRAME - 1);
      chk("b2b_ready", 32'(sample_ready), 32'd1);
      step(1'b1, 1'b1, 18'h3F000, 1'b0);
      chk("b2b_frame", 32'(ser_frame), 32'd1);
      chk("b2b_busy", 32'(busy), 32'd1);
      idle(10);
      // Drop mid-frame, then clear.
      step(1'b1, 1'b1, 18'h00555, 1'b0);
      chk("drop_ovf", 32'(overflow), 32'd1);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("clr_ovf", 32'(overflow), 32'd0);
      // Drop together with clear: set wins.
      step(1'b1, 1'b1, 18'h00555, 1'b1);
      chk("set_wins", 32'(overflow), 32'd1);
      idle(FRAME);

      // Reset mid-frame at bit 5.
      step(1'b1, 1'b1, 18'h1F000, 1'b0);
      idle(5 * CLK_DIV);
      step(1'b1, 1'b1, 18'h00555, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_data", 32'(ser_data), 32'd0);
      chk("rst_mid_ovf", 32'(overflow), 32'd0);
      run_frame(18'h00060, w, s);
      chk("post_rst_word", 32'(w), 32'h002);
      idle(3);

      // Sample-rate streaming: strobes spaced at or beyond a frame never drop.
      for (int n = 0; n < 20; n++) begin
         step(1'b1, 1'b1, IN_W'($urandom), 1'b0);
         idle(FRAME - 1 + int'($urandom_range(0, 6)));
      end
      chk("stream_ovf", 32'(overflow), 32'd0);

      // Random traffic including drops, clears and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 600) != 0, ($urandom % 24) == 0, IN_W'($urandom),
              ($urandom % 40) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_sample_tx.md
Name: fir_sample_tx

Overview:
- Output-side companion to fir_filter: takes each 18-bit filtered sample, requantizes it to a narrower signed word with round-half-up and saturation, and shifts it out MSB-first on a framed serial line.
- Carries filter results off-chip or to a DAC/codec link at the 48 kHz sample rate.
- Runs on the filter's clock.
- Sample-strobe input; a sample strobed while a frame is in flight is dropped and flagged.

Parameters:
- IN_W, 18, input sample width (signed two's complement); must equal fir_filter output width.
- OUT_W, 12, transmitted word width (signed); requires OUT_W <= IN_W - SHIFT + 1.
- SHIFT, 6, LSBs discarded by rounding; SHIFT >= 1.
- CLK_DIV, 4, clk cycles each serial bit is held; CLK_DIV >= 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- sample_in  in  IN_W  signed filter output
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle
- sample_ready  out  1  combinational; 1 when a strobe this cycle will be accepted
- ser_data  out  1  serial data, MSB first
- ser_frame  out  1  high for the whole MSB bit period only
- busy  out  1  high while a frame is being shifted
- sat  out  1  high during a frame whose word was saturated
- overflow  out  1  sticky; set when a strobe is dropped
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset: all registers cleared at the clk edge with rst=0. After reset: ser_data=0, ser_frame=0, busy=0, sat=0, overflow=0, FSM in IDLE. Reset mid-frame aborts the frame with no residual output.
- FSM states: IDLE and SHIFT.
- Requantize (combinational at accept):
  - sum = sext(sample_in, IN_W+1) + 2^(SHIFT-1)
  - q = sum >>> SHIFT (arithmetic shift)
  - If q > 2^(OUT_W-1)-1, word = max positive and sat=1.
  - If q < -2^(OUT_W-1), word = min negative and sat=1.
  - Otherwise word = q[OUT_W-1:0] and sat=0.
- Accept condition: sample_valid=1 and sample_ready=1. sample_ready = (state==IDLE) or (state==SHIFT and last bit index and div_cnt==CLK_DIV-1).
- On accept at edge N:
  - Shift register loaded with word; state goes to SHIFT.
  - bit_cnt=0, div_cnt=0.
  - From after edge N: busy=1, ser_frame=1, ser_data=word MSB, sat registered.
- Shifting:
  - div_cnt counts 0..CLK_DIV-1.
  - At wrap, bit_cnt increments and the shift register shifts left; ser_data = new MSB.
  - ser_frame drops after the first bit period (CLK_DIV cycles).
  - Each bit is held exactly CLK_DIV cycles; a frame lasts OUT_W*CLK_DIV cycles.
- End of frame (last bit, div_cnt==CLK_DIV-1):
  - With an accept: the new word loads with no gap; ser_frame=1 again next cycle.
  - Without an accept: go to IDLE with busy=0, ser_data=0, sat=0.
- Overflow:
  - sample_valid=1 with sample_ready=0 drops the sample and sets overflow.
  - ovf_clr=1 clears overflow next edge. If a drop and ovf_clr occur in the same cycle, set wins.
- CLK_DIV=1: each bit lasts one cycle, and back-to-back frames stream continuously.
- Sample-rate constraint: OUT_W*CLK_DIV must not exceed the sample period in clk cycles. Violations show only as overflow.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles while strobing sample_valid with 18'h00040 -> all outputs 0, no frame. Release rst, strobe 18'h00040 -> frame 12'h001 (64+32=96>>6=1); ser_frame high 4 cycles; busy high 48 cycles; sat=0.
- Rounding: strobe 95 -> 12'h001; strobe 96 -> 12'h002; strobe 18'h3FFDF (-33) -> 12'hFFF; strobe 18'h3FFE0 (-32) -> 12'h000.
- Saturation: strobe 18'h1FFFF -> 12'h7FF with sat=1. Strobe 18'h20000 -> 12'h800 with sat=0 (no clip). Strobe 18'h1FFDF -> 12'h7FF with sat=0.
- Back-to-back and drop:
  - Strobe A, then strobe B exactly on A's last frame cycle -> B's MSB follows with no gap and ser_frame re-asserts.
  - Strobe C mid-frame -> C dropped, overflow=1.
  - Pulse ovf_clr -> overflow=0.
  - ovf_clr in the same cycle as a drop -> overflow stays 1.
- Reset mid-frame: assert rst=0 at bit 5 of a frame -> next edge ser_data=0, busy=0, overflow=0. The next strobe after release starts a clean frame.
- End-to-end: drive fir_filter with the repeating 20-sample pattern (00, FA, FF, 54, 0A, 7F, E8, 7A, 6A, AC, 00, AC, 6A, 7A, E8, 7F, 0A, 54, FF, FA) at 48 kHz, and deserialize ser_data -> each word equals the reference model's rounded/saturated data_out; overflow stays 0.
